// File: rtl/led_anim_pkg.sv
//------------------------------------------------------------------------------
// led_anim_pkg
// Shared mode encoding and mode-stepping helpers for the LED animation blocks.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package led_anim_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SHIFT = 2'd0;
    localparam mode_t MODE_FILL  = 2'd1;
    localparam mode_t MODE_PWM   = 2'd2;
    localparam mode_t MODE_IDLE  = 2'd3;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_NEXT = 2'd1,
        STEP_PREV = 2'd2
    } step_t;

    function automatic mode_t mode_next(input mode_t m, input mode_t last);
        return (m == last) ? MODE_SHIFT : mode_t'(m + 2'd1);
    endfunction

    function automatic mode_t mode_prev(input mode_t m, input mode_t last);
        return (m == MODE_SHIFT) ? last : mode_t'(m - 2'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//------------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, stable-count debouncer and rising-edge press detect.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce
    import led_anim_pkg::*;
#(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);

    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          db_q;
    logic          db_d;
    logic          db_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any cycle where the synced level agrees with db restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn_raw;
            s2_q     <= s1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_db = db_q;
    assign press  = db_q & ~db_dly_q;

endmodule

`default_nettype wire

// File: rtl/mode_select.sv
//------------------------------------------------------------------------------
// mode_select
// Debounced next/prev buttons and optional auto-advance drive a wrapping mode.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mode_select
    import led_anim_pkg::*;
#(
    parameter int DEB_CYCLES  = 20,
    parameter int NUM_MODES   = 4,
    parameter int AUTO_PERIOD = 1000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  btn_next,
    input  logic  btn_prev,
    input  logic  auto_en,
    output mode_t mode,
    output logic  mode_changed,
    output logic  btn_next_db,
    output logic  btn_prev_db
);

    localparam mode_t         LAST_MODE = mode_t'(NUM_MODES - 1);
    localparam int            TW        = $clog2(AUTO_PERIOD + 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(AUTO_PERIOD - 1);

    logic          press_next;
    logic          press_prev;
    logic          auto_tick;
    step_t         step;
    mode_t         mode_q;
    mode_t         mode_d;
    logic          changed_q;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_next (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_next),
        .btn_db  (btn_next_db),
        .press   (press_next)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_prev (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_prev),
        .btn_db  (btn_prev_db),
        .press   (press_prev)
    );

    assign auto_tick = auto_en && (tmr_q == TMR_LAST);

    always_comb begin
        step   = STEP_NONE;
        mode_d = mode_q;
        tmr_d  = tmr_q + 1'b1;

        // Simultaneous presses cancel; a press always beats the auto tick.
        if (press_next && press_prev) begin
            step = STEP_NONE;
        end else if (press_next) begin
            step = STEP_NEXT;
        end else if (press_prev) begin
            step = STEP_PREV;
        end else if (auto_tick) begin
            step = STEP_NEXT;
        end

        case (step)
            STEP_NEXT: mode_d = mode_next(mode_q, LAST_MODE);
            STEP_PREV: mode_d = mode_prev(mode_q, LAST_MODE);
            default:   mode_d = mode_q;
        endcase

        if (press_next || press_prev || !auto_en || auto_tick) begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_SHIFT;
            changed_q <= 1'b0;
            tmr_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            changed_q <= (mode_d != mode_q);
            tmr_q     <= tmr_d;
        end
    end

    assign mode         = mode_q;
    assign mode_changed = changed_q;

endmodule

`default_nettype wire
